// File: rtl/decode_capture_buffer.sv
// Trigger-qualified circular capture FIFO for decoded I2C bytes, drained through rd_en/rd_valid.
// Optional: define CAPTURE_OVF_CNT_EN to add the saturating ovf_count[7:0] output.
module decode_capture_buffer #(
    parameter  int DEPTH = 16,
    parameter  int PCW   = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           arm,
    input  logic [7:0]     in_data,
    input  logic           in_valid,
    input  logic [7:0]     trig_value,
    input  logic [7:0]     trig_mask,
    input  logic [PCW-1:0] post_count,
    input  logic           rd_en,
    output logic [7:0]     rd_data,
    output logic           rd_valid,
    output logic [AW:0]    level,
    output logic [1:0]     state,
`ifdef CAPTURE_OVF_CNT_EN
    output logic [7:0]     ovf_count,
`endif
    output logic           triggered,
    output logic           overflow
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ARMED = 2'd1, S_POST = 2'd2, S_DONE = 2'd3} state_e;

    state_e         state_q, state_d;
    logic [7:0]     mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]    level_q, level_d;
    logic [PCW-1:0] cnt_q, cnt_d;
    logic [7:0]     rd_data_q, rd_data_d;
    logic           rd_valid_q, rd_valid_d;
    logic           trig_q, trig_d;
    logic           ovf_q, ovf_d;

    logic full, match, do_pop, do_wr, do_disc, do_drop;

    assign full   = (level_q == (AW+1)'(DEPTH));
    assign match  = in_valid && (((in_data ^ trig_value) & trig_mask) == 8'h00);
    // arm outranks any same-cycle pop or write
    assign do_pop = rd_en && !arm && (level_q != '0);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (arm) begin
            state_d = S_ARMED;
        end else begin
            case (state_q)
                S_ARMED: if (match) state_d = (post_count == '0) ? S_DONE : S_POST;
                S_POST:  if (in_valid && cnt_q <= PCW'(1)) state_d = S_DONE;
                default: state_d = state_q;
            endcase
        end
    end

    // Output / datapath control
    always_comb begin
        do_wr   = 1'b0;
        do_disc = 1'b0;
        do_drop = 1'b0;
        cnt_d   = cnt_q;
        trig_d  = trig_q;
        ovf_d   = ovf_q;
        if (arm) begin
            cnt_d  = '0;
            trig_d = 1'b0;
            ovf_d  = 1'b0;
        end else begin
            case (state_q)
                S_ARMED: begin
                    // Full pre-trigger history rolls: the oldest byte gives way unless a pop frees space
                    do_wr   = in_valid;
                    do_disc = in_valid && full && !do_pop;
                    if (match) begin
                        trig_d = 1'b1;
                        cnt_d  = post_count;
                    end
                end
                S_POST: begin
                    do_wr   = in_valid && (!full || do_pop);
                    do_drop = in_valid && full && !do_pop;
                    if (do_drop) ovf_d = 1'b1;
                    if (in_valid) cnt_d = cnt_q - PCW'(1);
                end
                default: ;
            endcase
        end

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (arm) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop || do_disc) rd_ptr_d = rd_ptr_q + AW'(1);
            if (do_wr && !(do_pop || do_disc))      level_d = level_q + (AW+1)'(1);
            else if (!do_wr && (do_pop || do_disc)) level_d = level_q - (AW+1)'(1);
        end

        rd_valid_d = do_pop;
        rd_data_d  = do_pop ? mem_q[rd_ptr_q] : rd_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            cnt_q      <= '0;
            rd_data_q  <= 8'h00;
            rd_valid_q <= 1'b0;
            trig_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            cnt_q      <= cnt_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            trig_q     <= trig_d;
            ovf_q      <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= in_data;
    end

`ifdef CAPTURE_OVF_CNT_EN
    logic [7:0] ovf_cnt_q, ovf_cnt_d;

    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (arm)                                ovf_cnt_d = 8'h00;
        else if (do_drop && ovf_cnt_q != 8'hFF) ovf_cnt_d = ovf_cnt_q + 8'h01;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_cnt_q <= 8'h00;
        else        ovf_cnt_q <= ovf_cnt_d;
    end

    assign ovf_count = ovf_cnt_q;
`endif

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign level     = level_q;
    assign state     = state_q;
    assign triggered = trig_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_decode_capture_buffer.sv
// Bench for decode_capture_buffer: directed scenarios plus random traffic against a queue-based model.
module tb_decode_capture_buffer;
    localparam int DEPTH = 16;
    localparam int PCW   = 4;
    localparam int AW    = $clog2(DEPTH);

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           arm = 1'b0;
    logic [7:0]     in_data = 8'h00;
    logic           in_valid = 1'b0;
    logic [7:0]     trig_value = 8'h00;
    logic [7:0]     trig_mask = 8'hFF;
    logic [PCW-1:0] post_count = '0;
    logic           rd_en = 1'b0;
    logic [7:0]     rd_data;
    logic           rd_valid;
    logic [AW:0]    level;
    logic [1:0]     state;
    logic           triggered;
    logic           overflow;
`ifdef CAPTURE_OVF_CNT_EN
    logic [7:0]     ovf_count;
`endif

    decode_capture_buffer #(.DEPTH(DEPTH), .PCW(PCW)) dut (
        .clk(clk), .rst_n(rst_n), .arm(arm), .in_data(in_data), .in_valid(in_valid),
        .trig_value(trig_value), .trig_mask(trig_mask), .post_count(post_count),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .level(level),
        .state(state),
`ifdef CAPTURE_OVF_CNT_EN
        .ovf_count(ovf_count),
`endif
        .triggered(triggered), .overflow(overflow)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference model: captured bytes as a queue, phase as a small integer (0 idle .. 3 done)
    logic [7:0] exp_q[$];
    int         m_state = 0;
    logic [7:0] m_rd_data = 8'h00;
    logic       m_rd_valid = 1'b0;
    logic       m_trig = 1'b0;
    logic       m_ovf = 1'b0;
    int         m_cnt = 0;
    int         m_ovfc = 0;

    task automatic model_step();
        bit hit;
        m_rd_valid = 1'b0;
        if (arm) begin
            exp_q.delete();
            m_state = 1; m_trig = 1'b0; m_ovf = 1'b0; m_cnt = 0; m_ovfc = 0;
        end else begin
            if (rd_en && exp_q.size() > 0) begin
                m_rd_data  = exp_q.pop_front();
                m_rd_valid = 1'b1;
            end
            if (in_valid) begin
                hit = ((in_data ^ trig_value) & trig_mask) == 8'h00;
                if (m_state == 1) begin
                    if (exp_q.size() == DEPTH) exp_q.delete(0);
                    exp_q.push_back(in_data);
                    if (hit) begin
                        m_trig  = 1'b1;
                        m_cnt   = int'(post_count);
                        m_state = (post_count == 0) ? 3 : 2;
                    end
                end else if (m_state == 2) begin
                    if (exp_q.size() < DEPTH) exp_q.push_back(in_data);
                    else begin
                        m_ovf = 1'b1;
                        if (m_ovfc < 255) m_ovfc++;
                    end
                    m_cnt--;
                    if (m_cnt == 0) m_state = 3;
                end
            end
        end
    endtask

    task automatic compare_all();
        check("state", 32'(state), 32'(m_state));
        check("level", 32'(level), 32'(exp_q.size()));
        check("rd_valid", 32'(rd_valid), 32'(m_rd_valid));
        check("rd_data", 32'(rd_data), 32'(m_rd_data));
        check("triggered", 32'(triggered), 32'(m_trig));
        check("overflow", 32'(overflow), 32'(m_ovf));
`ifdef CAPTURE_OVF_CNT_EN
        check("ovf_count", 32'(ovf_count), 32'(m_ovfc));
`endif
    endtask

    // driver: hold inputs across one rising edge, advance the model, sample 1 ns later
    task automatic drive(input logic a, input logic iv, input logic [7:0] d, input logic re);
        arm = a; in_valid = iv; in_data = d; rd_en = re;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        arm = 1'b0; in_valid = 1'b0; rd_en = 1'b0;
    endtask

    logic [7:0] t1_bytes [6] = '{8'h11, 8'h22, 8'hA5, 8'h33, 8'h44, 8'h55};
    logic [7:0] t1_exp   [5] = '{8'h11, 8'h22, 8'hA5, 8'h33, 8'h44};

    initial begin
        int k;
        // reset
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'h00);
        check("rst_triggered", 32'(triggered), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // bytes while idle are ignored
        drive(0, 1, 8'h5A, 0);
        check("idle_level", 32'(level), 32'd0);

        // basic trigger with post_count=2
        trig_mask = 8'hFF; trig_value = 8'hA5; post_count = 4'd2;
        drive(1, 0, 8'h00, 0);
        for (int i = 0; i < 6; i++) begin
            drive(0, 1, t1_bytes[i], 0);
            if (i == 4) check("t1_done_after_44", 32'(state), 32'd3);
        end
        check("t1_level", 32'(level), 32'd5);
        k = 0;
        for (int i = 0; i < 7; i++) begin
            drive(0, 0, 8'h00, 1);
            if (rd_valid) begin
                if (k < 5) check("t1_rd", 32'(rd_data), 32'(t1_exp[k]));
                k++;
            end
        end
        check("t1_nreads", 32'(k), 32'd5);

        // pre-trigger history wraps without overflow
        trig_value = 8'hEE; trig_mask = 8'hFF;
        drive(1, 0, 8'h00, 0);
        for (int i = 0; i < 20; i++) drive(0, 1, 8'(i), 0);
        check("t3_level", 32'(level), 32'd16);
        check("t3_overflow", 32'(overflow), 32'd0);
        drive(0, 0, 8'h00, 1);
        check("t3_first_rd", 32'(rd_data), 32'd4);
        check("t3_first_rv", 32'(rd_valid), 32'd1);

        // mask 0 triggers on anything, post 0 finishes at once
        trig_mask = 8'h00; post_count = 4'd0;
        drive(1, 0, 8'h00, 0);
        drive(0, 1, 8'h77, 0);
        check("t4_state", 32'(state), 32'd3);
        check("t4_level", 32'(level), 32'd1);
        drive(0, 1, 8'h78, 0);
        check("t4_frozen", 32'(level), 32'd1);

        // post phase overflow: 14 pre + trigger leaves room for one of five post bytes
        trig_mask = 8'hFF; trig_value = 8'hA5; post_count = 4'd5;
        drive(1, 0, 8'h00, 0);
        for (int i = 0; i < 14; i++) drive(0, 1, 8'(i), 0);
        drive(0, 1, 8'hA5, 0);
        for (int i = 0; i < 5; i++) drive(0, 1, 8'(8'h60 + i), 0);
        check("t5_overflow", 32'(overflow), 32'd1);
        check("t5_state", 32'(state), 32'd3);
        check("t5_level", 32'(level), 32'd16);
`ifdef CAPTURE_OVF_CNT_EN
        check("t5_ovf_count", 32'(ovf_count), 32'd4);
`endif

        // empty read, then arm beating a same-cycle byte and pop
        drive(1, 0, 8'h00, 0);
        drive(0, 0, 8'h00, 1);
        check("t6_empty_rv", 32'(rd_valid), 32'd0);
        drive(0, 1, 8'h01, 0);
        drive(0, 1, 8'h02, 0);
        drive(1, 1, 8'h03, 1);
        check("t6_level", 32'(level), 32'd0);
        check("t6_rv", 32'(rd_valid), 32'd0);
        check("t6_state", 32'(state), 32'd1);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                trig_value = 8'($urandom_range(0, 15));
                case ($urandom_range(0, 3))
                    0:       trig_mask = 8'h00;
                    1:       trig_mask = 8'h0C;
                    default: trig_mask = 8'hFF;
                endcase
            end
            post_count = PCW'($urandom_range(0, 2**PCW - 1));
            drive(($urandom_range(0, 119) == 0), ($urandom_range(0, 1) == 1),
                  8'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
